// File: rtl/seq_detect_param.sv
// -----------------------------------------------------------------------------
// seq_detect_param
//
// Serial pattern detector with a run-time programmable LEN-bit pattern. A
// Mealy match pulse (dataout) is raised in the same cycle as the final bit of
// the pattern. Overlapping or non-overlapping detection is selected each cycle
// by overlap_en. The block also keeps a saturating count of matches.
//
// Stream qualification: datain is consumed on a rising clock edge only when
// datain_valid is high. There is no back-pressure, so every valid bit is
// accepted. Cycles with datain_valid low are invisible to the detector: no
// shift, no fill change, no match.
//
// Parameters
//   LEN             pattern length in bits (2..32)
//   DEFAULT_PATTERN pattern loaded at reset; the first-received bit is the MSB
//   CNT_W           width of the match counter
//
// Ports
//   clock         system clock, all state on the rising edge
//   reset         synchronous, active-high reset
//   datain        serial data bit
//   datain_valid  qualifies datain
//   overlap_en    1 = a suffix of a match may begin the next match
//   pattern_in    new pattern value
//   pattern_load  load pattern_in; discards the bit presented in that cycle
//   dataout       Mealy match pulse (combinational from the current bit)
//   match_count   saturating match count
//   fill_level    number of valid history bits held (debug view of state)
// -----------------------------------------------------------------------------
module seq_detect_param #(
  parameter int             LEN             = 5,
  parameter logic [LEN-1:0] DEFAULT_PATTERN = 5'b11101,
  parameter int             CNT_W           = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   datain,
  input  logic                   datain_valid,
  input  logic                   overlap_en,
  input  logic [LEN-1:0]         pattern_in,
  input  logic                   pattern_load,
  output logic                   dataout,
  output logic [CNT_W-1:0]       match_count,
  output logic [$clog2(LEN):0]   fill_level
);

  localparam int FILL_W = $clog2(LEN) + 1;

  // fill saturates here: the history holds LEN-1 bits, the LEN-th bit is
  // the live datain.
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(LEN - 1);

  logic [LEN-1:0]    pattern_q;
  logic [LEN-2:0]    history_q;
  logic [FILL_W-1:0] fill_q;
  logic [CNT_W-1:0]  count_q;

  logic [LEN-1:0]    window;
  logic              match;

  // The compare window is the stored history plus the bit being presented,
  // which is what gives zero-latency detection on the final bit.
  always_comb begin
    window = {history_q, datain};
    match  = datain_valid && !reset && !pattern_load &&
             (fill_q == FILL_FULL) && (window == pattern_q);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pattern_q <= DEFAULT_PATTERN;
      history_q <= '0;
      fill_q    <= '0;
      count_q   <= '0;
    end else if (pattern_load) begin
      // The bit presented with the load is dropped; the count survives.
      pattern_q <= pattern_in;
      history_q <= '0;
      fill_q    <= '0;
    end else if (datain_valid) begin
      history_q <= window[LEN-2:0];

      // Non-overlap restarts the fill so the next match needs LEN fresh
      // bits; the stale history is harmless because fill gates the compare.
      if (match && !overlap_en) begin
        fill_q <= '0;
      end else if (fill_q != FILL_FULL) begin
        fill_q <= fill_q + 1'b1;
      end

      if (match && (count_q != '1)) begin
        count_q <= count_q + 1'b1;
      end
    end
  end

  assign dataout     = match;
  assign match_count = count_q;
  assign fill_level  = fill_q;

endmodule

// File: tb/tb_seq_detect_param.sv
// -----------------------------------------------------------------------------
// tb_seq_detect_param
//
// Directed bench for seq_detect_param. Two instances share all inputs: dut_a
// uses the default 16-bit counter, dut_b a 4-bit counter to reach saturation
// quickly. Inputs change on the falling edge (or just after the rising edge);
// outputs are sampled 1 time unit after the falling edge.
// -----------------------------------------------------------------------------
module tb_seq_detect_param;

  // ---------------------------------------------------------------- clock/reset
  logic clock;
  logic reset;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------------------------------------------------------- DUT wiring
  logic        datain;
  logic        datain_valid;
  logic        overlap_en;
  logic [4:0]  pattern_in;
  logic        pattern_load;

  logic        dataout_a;
  logic [15:0] count_a;
  logic [3:0]  fill_a;

  logic        dataout_b;
  logic [3:0]  count_b;
  logic [3:0]  fill_b;

  seq_detect_param #(
    .LEN(5), .DEFAULT_PATTERN(5'b11101), .CNT_W(16)
  ) dut_a (
    .clock        (clock),
    .reset        (reset),
    .datain       (datain),
    .datain_valid (datain_valid),
    .overlap_en   (overlap_en),
    .pattern_in   (pattern_in),
    .pattern_load (pattern_load),
    .dataout      (dataout_a),
    .match_count  (count_a),
    .fill_level   (fill_a)
  );

  seq_detect_param #(
    .LEN(5), .DEFAULT_PATTERN(5'b11101), .CNT_W(4)
  ) dut_b (
    .clock        (clock),
    .reset        (reset),
    .datain       (datain),
    .datain_valid (datain_valid),
    .overlap_en   (overlap_en),
    .pattern_in   (pattern_in),
    .pattern_load (pattern_load),
    .dataout      (dataout_b),
    .match_count  (count_b),
    .fill_level   (fill_b)
  );

  // ---------------------------------------------------------------- scoreboard
  int n_tests = 0;
  int n_fail  = 0;
  logic [0:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------------------------------------------------------- drivers
  // Present one valid bit, check the Mealy output, then let the edge happen.
  task automatic drive_bit(input logic d, input logic exp_match);
    @(negedge clock);
    datain       = d;
    datain_valid = 1'b1;
    pattern_load = 1'b0;
    #1;
    check("dataout_a", {31'd0, dataout_a}, {31'd0, exp_match});
    check("dataout_b", {31'd0, dataout_b}, {31'd0, exp_match});
    @(posedge clock);
    #1;
    datain_valid = 1'b0;
  endtask

  // Invalid cycles carry datain=1, which would complete 11101 if not ignored.
  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clock);
      datain_valid = 1'b0;
      datain       = 1'b1;
      #1;
      check("idle_dataout_a", {31'd0, dataout_a}, 32'd0);
      check("idle_dataout_b", {31'd0, dataout_b}, 32'd0);
      @(posedge clock);
      #1;
    end
  endtask

  // bits/exp are MSB-first (first bit sent = bit n-1); gap invalid cycles
  // are inserted between consecutive bits.
  task automatic send_seq(input logic [31:0] bits, input logic [31:0] exp,
                          input int n, input int gap);
    for (int i = 0; i < n; i++) exp_q.push_back(exp[n-1-i]);
    for (int i = 0; i < n; i++) begin
      drive_bit(bits[n-1-i], exp_q.pop_front());
      if (i != n - 1) idle(gap);
    end
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset        = 1'b1;
    datain_valid = 1'b0;
    pattern_load = 1'b0;
    @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  // Load with a valid '1' presented in the same cycle; it must be discarded.
  task automatic do_load(input logic [4:0] p);
    @(negedge clock);
    pattern_in   = p;
    pattern_load = 1'b1;
    datain_valid = 1'b1;
    datain       = 1'b1;
    #1;
    check("load_dataout_a", {31'd0, dataout_a}, 32'd0);
    @(posedge clock);
    #1;
    pattern_load = 1'b0;
    datain_valid = 1'b0;
  endtask

  // ---------------------------------------------------------------- stimulus
  initial begin
    reset        = 1'b1;
    datain       = 1'b0;
    datain_valid = 1'b0;
    overlap_en   = 1'b1;
    pattern_in   = 5'b00000;
    pattern_load = 1'b0;

    repeat (2) @(posedge clock);
    #1;
    check("rst_dataout", {31'd0, dataout_a}, 32'd0);
    check("rst_fill",    {28'd0, fill_a},    32'd0);
    check("rst_count",   {16'd0, count_a},   32'd0);
    reset = 1'b0;

    // Overlap mode: 1,1,1,0,1,1,1,0,1 -> matches on bits 5 and 9.
    overlap_en = 1'b1;
    send_seq(32'b111011101, 32'b000010001, 9, 0);
    check("ovl_count", {16'd0, count_a}, 32'd2);

    // Non-overlap: only bit 5 matches; fill restarts from 0.
    do_reset();
    overlap_en = 1'b0;
    send_seq(32'b11101, 32'b00001, 5, 0);
    check("novl_fill5", {28'd0, fill_a}, 32'd0);
    send_seq(32'b1101, 32'b0000, 4, 0);
    check("novl_fill9",  {28'd0, fill_a},  32'd4);
    check("novl_count",  {16'd0, count_a}, 32'd1);

    // Gaps of 3 invalid cycles between bits are transparent.
    do_reset();
    overlap_en = 1'b1;
    send_seq(32'b11101, 32'b00001, 5, 3);
    check("gap_count", {16'd0, count_a}, 32'd1);

    // Pattern load while fill=3; count is preserved across the load.
    do_reset();
    overlap_en = 1'b0;
    send_seq(32'b11101, 32'b00001, 5, 0);
    send_seq(32'b111, 32'b000, 3, 0);
    check("pre_load_fill",  {28'd0, fill_a},  32'd3);
    do_load(5'b10101);
    check("post_load_fill",  {28'd0, fill_a},  32'd0);
    check("post_load_count", {16'd0, count_a}, 32'd1);
    overlap_en = 1'b1;
    send_seq(32'b1010101, 32'b0000101, 7, 0);
    check("load_count", {16'd0, count_a}, 32'd3);

    // 20 back-to-back overlapping matches of 11111: 4-bit counter saturates.
    do_reset();
    do_load(5'b11111);
    send_seq(32'hFF_FFFF, 32'h0F_FFFF, 24, 0);
    check("sat_count_b", {28'd0, count_b}, 32'd15);
    check("sat_count_a", {16'd0, count_a}, 32'd20);

    // Reset (together with a load) arrives as the 5th bit of 11101.
    do_reset();
    overlap_en = 1'b1;
    send_seq(32'b1110, 32'b0000, 4, 0);
    @(negedge clock);
    reset        = 1'b1;
    pattern_load = 1'b1;
    pattern_in   = 5'b10101;
    datain_valid = 1'b1;
    datain       = 1'b1;
    #1;
    check("rst_mid_dataout_a", {31'd0, dataout_a}, 32'd0);
    check("rst_mid_dataout_b", {31'd0, dataout_b}, 32'd0);
    @(posedge clock);
    #1;
    reset        = 1'b0;
    pattern_load = 1'b0;
    datain_valid = 1'b0;
    check("rst_mid_count", {16'd0, count_a}, 32'd0);
    check("rst_mid_fill",  {28'd0, fill_a},  32'd0);
    // Default pattern must be back, and the old history must not help.
    send_seq(32'b1, 32'b0, 1, 0);
    send_seq(32'b1101, 32'b0001, 4, 0);
    check("rst_mid_count2", {16'd0, count_a}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
